// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: stall/flush enables, ALU operand forwarding, multi-cycle EX hold.
// Outputs are combinational (latency 0); define HAZARD_PERF_EN for saturating stall/redirect counters.
module hazard_ctrl #(
  parameter int REG_AW     = 5,
  parameter int PC_W       = 16,
  parameter int MC_LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rn,
  input  logic [REG_AW-1:0] id_rm,
  input  logic              id_uses_rn,
  input  logic              id_uses_rm,
  input  logic [REG_AW-1:0] ex_rn,
  input  logic [REG_AW-1:0] ex_rm,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_to_reg,
  input  logic              ex_multicycle,
  input  logic              ex_branch_taken,
  input  logic [PC_W-1:0]   ex_branch_target,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              mem_reg_write,
  input  logic              wb_reg_write,
  output logic              stall_pc,
  output logic              stall_if_id,
  output logic              stall_id_ex,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              flush_ex_mem,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              pc_redirect,
  output logic [PC_W-1:0]   pc_redirect_target,
`ifdef HAZARD_PERF_EN
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt,
`endif
  output logic              mc_done
);

  typedef enum logic {RUN = 1'b0, MC_WAIT = 1'b1} state_t;

  // Entry cycle is the first of MC_LATENCY occupancy cycles; cnt==0 marks the last.
  localparam logic [7:0] MC_RELOAD = (MC_LATENCY > 1) ? 8'(MC_LATENCY - 2) : 8'd0;
  localparam bit         MC_SINGLE = (MC_LATENCY == 1);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       load_use;

  assign load_use = ex_mem_to_reg & ex_reg_write &
                    ((id_uses_rn & (id_rn == ex_rd)) | (id_uses_rm & (id_rm == ex_rd)));

  always_comb begin
    state_nxt          = state;
    cnt_nxt            = cnt;
    stall_pc           = 1'b0;
    stall_if_id        = 1'b0;
    stall_id_ex        = 1'b0;
    flush_if_id        = 1'b0;
    flush_id_ex        = 1'b0;
    flush_ex_mem       = 1'b0;
    fwd_a              = 2'b00;
    fwd_b              = 2'b00;
    pc_redirect        = 1'b0;
    pc_redirect_target = '0;
    mc_done            = 1'b0;
    if (rst) begin
      pc_redirect_target = ex_branch_target;
      if (mem_reg_write && (mem_rd == ex_rn))     fwd_a = 2'b10;
      else if (wb_reg_write && (wb_rd == ex_rn))  fwd_a = 2'b01;
      if (mem_reg_write && (mem_rd == ex_rm))     fwd_b = 2'b10;
      else if (wb_reg_write && (wb_rd == ex_rm))  fwd_b = 2'b01;
      case (state)
        RUN: begin
          if (ex_branch_taken) begin
            pc_redirect = 1'b1;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end else if (ex_multicycle) begin
            if (MC_SINGLE) begin
              mc_done = 1'b1;
            end else begin
              stall_pc     = 1'b1;
              stall_if_id  = 1'b1;
              stall_id_ex  = 1'b1;
              flush_ex_mem = 1'b1;
              cnt_nxt      = MC_RELOAD;
              state_nxt    = MC_WAIT;
            end
          end else if (load_use) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end
        end
        MC_WAIT: begin
          // EX is frozen here, so branch/load-use/multicycle inputs cannot carry new events.
          if (cnt != 8'd0) begin
            stall_pc     = 1'b1;
            stall_if_id  = 1'b1;
            stall_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
            cnt_nxt      = cnt - 8'd1;
          end else begin
            mc_done   = 1'b1;
            state_nxt = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt <= 32'd0;
      perf_flush_cnt <= 32'd0;
    end else begin
      if (stall_pc && (perf_stall_cnt != 32'hFFFF_FFFF))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (pc_redirect && (perf_flush_cnt != 32'hFFFF_FFFF))
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: occupancy-based reference model checked every cycle on two
// instances (MC_LATENCY 4 and 1), plus directed vectors with literal expectations.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rn, id_rm, ex_rn, ex_rm, ex_rd, mem_rd, wb_rd;
  logic        id_uses_rn, id_uses_rm, ex_reg_write, ex_mem_to_reg;
  logic        ex_multicycle, ex_branch_taken, mem_reg_write, wb_reg_write;
  logic [15:0] ex_branch_target;

  logic        a_stall_pc, a_stall_if_id, a_stall_id_ex, a_flush_if_id, a_flush_id_ex, a_flush_ex_mem;
  logic        a_pc_redirect, a_mc_done;
  logic [1:0]  a_fwd_a, a_fwd_b;
  logic [15:0] a_target;
  logic        b_stall_pc, b_stall_if_id, b_stall_id_ex, b_flush_if_id, b_flush_id_ex, b_flush_ex_mem;
  logic        b_pc_redirect, b_mc_done;
  logic [1:0]  b_fwd_a, b_fwd_b;
  logic [15:0] b_target;
`ifdef HAZARD_PERF_EN
  logic [31:0] a_perf_stall, a_perf_flush, b_perf_stall, b_perf_flush;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int left4    = 0;
  int left1    = 0;

  hazard_ctrl #(.REG_AW(5), .PC_W(16), .MC_LATENCY(4)) dut_a (
    .clk(clk), .rst(rst), .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
    .ex_rn(ex_rn), .ex_rm(ex_rm), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_multicycle(ex_multicycle), .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .stall_pc(a_stall_pc), .stall_if_id(a_stall_if_id), .stall_id_ex(a_stall_id_ex),
    .flush_if_id(a_flush_if_id), .flush_id_ex(a_flush_id_ex), .flush_ex_mem(a_flush_ex_mem),
    .fwd_a(a_fwd_a), .fwd_b(a_fwd_b), .pc_redirect(a_pc_redirect), .pc_redirect_target(a_target),
`ifdef HAZARD_PERF_EN
    .perf_stall_cnt(a_perf_stall), .perf_flush_cnt(a_perf_flush),
`endif
    .mc_done(a_mc_done)
  );

  hazard_ctrl #(.REG_AW(5), .PC_W(16), .MC_LATENCY(1)) dut_b (
    .clk(clk), .rst(rst), .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
    .ex_rn(ex_rn), .ex_rm(ex_rm), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_multicycle(ex_multicycle), .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .stall_pc(b_stall_pc), .stall_if_id(b_stall_if_id), .stall_id_ex(b_stall_id_ex),
    .flush_if_id(b_flush_if_id), .flush_id_ex(b_flush_id_ex), .flush_ex_mem(b_flush_ex_mem),
    .fwd_a(b_fwd_a), .fwd_b(b_fwd_b), .pc_redirect(b_pc_redirect), .pc_redirect_target(b_target),
`ifdef HAZARD_PERF_EN
    .perf_stall_cnt(b_perf_stall), .perf_flush_cnt(b_perf_flush),
`endif
    .mc_done(b_mc_done)
  );

  wire [27:0] a_vec = {a_stall_pc, a_stall_if_id, a_stall_id_ex, a_flush_if_id, a_flush_id_ex,
                       a_flush_ex_mem, a_pc_redirect, a_mc_done, a_fwd_a, a_fwd_b, a_target};
  wire [27:0] b_vec = {b_stall_pc, b_stall_if_id, b_stall_id_ex, b_flush_if_id, b_flush_id_ex,
                       b_flush_ex_mem, b_pc_redirect, b_mc_done, b_fwd_a, b_fwd_b, b_target};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference: 'left' = remaining EX occupancy cycles of the current multi-cycle op (0 = none).
  function automatic logic [27:0] model_out(input int lat, input int left);
    logic hold, done, bubble, redirect, lu;
    logic [1:0] fa, fb;
    if (!rst) return 28'd0;
    fa = (mem_reg_write && mem_rd == ex_rn) ? 2'b10 : (wb_reg_write && wb_rd == ex_rn) ? 2'b01 : 2'b00;
    fb = (mem_reg_write && mem_rd == ex_rm) ? 2'b10 : (wb_reg_write && wb_rd == ex_rm) ? 2'b01 : 2'b00;
    lu = ex_mem_to_reg && ex_reg_write &&
         ((id_uses_rn && id_rn == ex_rd) || (id_uses_rm && id_rm == ex_rd));
    hold = 0; done = 0; bubble = 0; redirect = 0;
    if (left > 1)             hold = 1;
    else if (left == 1)       done = 1;
    else if (ex_branch_taken) redirect = 1;
    else if (ex_multicycle) begin
      if (lat > 1) hold = 1;
      else         done = 1;
    end else if (lu)          bubble = 1;
    return {hold | bubble, hold | bubble, hold, redirect, redirect | bubble, hold, redirect, done,
            fa, fb, ex_branch_target};
  endfunction

  function automatic int model_next(input int lat, input int left);
    if (!rst)     return 0;
    if (left > 0) return left - 1;
    if (!ex_branch_taken && ex_multicycle && lat > 1) return lat - 1;
    return 0;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      left4 = 0;
      left1 = 0;
    end
    chk("model_lat4", {4'd0, a_vec}, {4'd0, model_out(4, left4)});
    chk("model_lat1", {4'd0, b_vec}, {4'd0, model_out(1, left1)});
    left4 = model_next(4, left4);
    left1 = model_next(1, left1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rn = 0; id_rm = 0; id_uses_rn = 0; id_uses_rm = 0;
    ex_rn = 0; ex_rm = 0; ex_rd = 0; ex_reg_write = 0; ex_mem_to_reg = 0;
    ex_multicycle = 0; ex_branch_taken = 0; ex_branch_target = 16'h0000;
    mem_rd = 0; wb_rd = 0; mem_reg_write = 0; wb_reg_write = 0;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    ex_branch_taken = 1; ex_branch_target = 16'h1234; mem_reg_write = 1; mem_rd = 3; ex_rn = 3;
    #2;
    chk("reset_redirect", {31'd0, a_pc_redirect}, 32'd0);
    chk("reset_target", {16'd0, a_target}, 32'd0);
    chk("reset_fwd_a", {30'd0, a_fwd_a}, 32'd0);
    tick(); tick();
    rst = 1'b1; idle();

    // load-use: EX loads r5, ID reads r5
    tick();
    ex_mem_to_reg = 1; ex_reg_write = 1; ex_rd = 5; id_rn = 5; id_uses_rn = 1;
    #1;
    chk("lu_stall_pc", {31'd0, a_stall_pc}, 32'd1);
    chk("lu_stall_if_id", {31'd0, a_stall_if_id}, 32'd1);
    chk("lu_flush_id_ex", {31'd0, a_flush_id_ex}, 32'd1);
    chk("lu_stall_id_ex", {31'd0, a_stall_id_ex}, 32'd0);
    tick(); idle(); id_rn = 5; id_uses_rn = 1;
    #1;
    chk("lu_next_stall", {31'd0, a_stall_pc}, 32'd0);

    // forwarding priority and register 0
    tick(); idle();
    mem_rd = 3; wb_rd = 3; mem_reg_write = 1; wb_reg_write = 1; ex_rn = 3; ex_rm = 7;
    #1;
    chk("fwd_a_mem", {30'd0, a_fwd_a}, 32'd2);
    chk("fwd_b_none", {30'd0, a_fwd_b}, 32'd0);
    tick(); mem_reg_write = 0;
    #1;
    chk("fwd_a_wb", {30'd0, a_fwd_a}, 32'd1);
    tick(); idle(); mem_reg_write = 1;
    #1;
    chk("fwd_r0_a", {30'd0, a_fwd_a}, 32'd2);
    chk("fwd_r0_b", {30'd0, a_fwd_b}, 32'd2);

    // clean restart, then multi-cycle op held in EX for its occupancy
    tick(); idle(); rst = 0;
    tick(); rst = 1;
    for (int c = 1; c <= 4; c++) begin
      tick(); ex_multicycle = 1;
      #1;
      chk($sformatf("mc4_stall_c%0d", c), {31'd0, a_stall_pc}, (c <= 3) ? 32'd1 : 32'd0);
      chk($sformatf("mc4_done_c%0d", c), {31'd0, a_mc_done}, (c == 4) ? 32'd1 : 32'd0);
      if (c == 1) begin
        chk("mc1_done", {31'd0, b_mc_done}, 32'd1);
        chk("mc1_stall", {31'd0, b_stall_pc}, 32'd0);
      end
    end
    tick(); idle();
    #1;
    chk("mc4_run_stall", {31'd0, a_stall_pc}, 32'd0);
    chk("mc4_run_done", {31'd0, a_mc_done}, 32'd0);

    // branch wins over a simultaneous load-use match
    tick();
    ex_branch_taken = 1; ex_branch_target = 16'h0040;
    ex_mem_to_reg = 1; ex_reg_write = 1; ex_rd = 9; id_rm = 9; id_uses_rm = 1;
    #1;
    chk("br_redirect", {31'd0, a_pc_redirect}, 32'd1);
    chk("br_target", {16'd0, a_target}, 32'h0040);
    chk("br_flush_if_id", {31'd0, a_flush_if_id}, 32'd1);
    chk("br_flush_id_ex", {31'd0, a_flush_id_ex}, 32'd1);
    chk("br_no_stall", {31'd0, a_stall_pc}, 32'd0);
    tick(); idle();
`ifdef HAZARD_PERF_EN
    #1;
    chk("perf_stall", a_perf_stall, 32'd3);
    chk("perf_flush", a_perf_flush, 32'd1);
`endif

    // back-to-back multi-cycle ops
    for (int c = 1; c <= 8; c++) begin
      tick(); ex_multicycle = 1;
      #1;
      if (c == 5) chk("b2b_restall", {31'd0, a_stall_pc}, 32'd1);
    end
    tick(); idle();

    // reset during the second MC_WAIT cycle
    tick(); ex_multicycle = 1;
    tick(); tick();
    rst = 0;
    #1;
    chk("rst_mid_vec", {4'd0, a_vec}, 32'd0);
    tick(); rst = 1; idle();
    #1;
    chk("rst_after_done", {31'd0, a_mc_done}, 32'd0);
    chk("rst_after_stall", {31'd0, a_stall_pc}, 32'd0);
    for (int c = 0; c < 5; c++) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
